// File: rtl/data_mem.sv
// Data memory for the load/store unit: byte-addressed, little-endian,
// combinational loads, clocked stores, whole array cleared by reset.
module data_mem #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        misalign
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0] mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic              is_b;
  logic              is_h;
  logic              is_w;
  logic              is_x;
  logic              wr_en;
  logic [31:0]       word;
  logic [31:0]       sh;
  logic [31:0]       wdata;
  logic [3:0]        be;
  logic              unused_addr;

  assign idx  = addr[ADDR_W+1:2];
  assign is_b = (mem_size == 2'b00);
  assign is_h = (mem_size == 2'b01);
  assign is_w = (mem_size == 2'b10);
  assign is_x = (mem_size == 2'b11);

  // upper address bits wrap away by design
  assign unused_addr = ^addr[31:ADDR_W+2];

  assign misalign = (mem_read | mem_write) &
                    ((is_h & addr[0]) |
                     (is_w & (addr[1:0] != 2'b00)) |
                     is_x);

  assign wr_en = mem_write & ~misalign;
  assign word  = mem[idx];
  assign sh    = word >> {addr[1:0], 3'b000};

  always_comb begin
    read_data = '0;
    if (mem_read && !misalign) begin
      unique case (1'b1)
        is_b:    read_data = {{24{~mem_unsigned & sh[7]}}, sh[7:0]};
        is_h:    read_data = {{16{~mem_unsigned & sh[15]}}, sh[15:0]};
        is_w:    read_data = word;
        default: read_data = '0;
      endcase
    end
  end

  always_comb begin
    wdata = write_data;
    be    = 4'b0000;
    unique case (1'b1)
      is_b: begin
        wdata = {4{write_data[7:0]}};
        be    = 4'b0001 << addr[1:0];
      end
      is_h: begin
        wdata = {2{write_data[15:0]}};
        be    = addr[1] ? 4'b1100 : 4'b0011;
      end
      is_w:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) begin
          mem[idx][8*l +: 8] <= wdata[8*l +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Directed-vector bench for data_mem.
// Loads are checked combinationally, stores just after the edge.
module tb_data_mem;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        misalign;

  int n_chk;
  int n_err;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  data_mem #(.ADDR_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .addr         (addr),
    .write_data   (write_data),
    .read_data    (read_data),
    .misalign     (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_size     = SZ_W;
    mem_unsigned = 1'b0;
    addr         = '0;
    write_data   = '0;
  endtask

  task automatic store(input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [1:0]  sz);
    mem_read   = 1'b0;
    mem_write  = 1'b1;
    mem_size   = sz;
    addr       = a;
    write_data = d;
    @(posedge clk);
    #1;
    mem_write  = 1'b0;
  endtask

  task automatic load(input  logic [31:0] a,
                      input  logic [1:0]  sz,
                      input  logic        uns,
                      output logic [31:0] rd);
    mem_read     = 1'b1;
    mem_write    = 1'b0;
    mem_size     = sz;
    mem_unsigned = uns;
    addr         = a;
    #1;
    rd = read_data;
  endtask

  logic [31:0] rd;

  initial begin
    n_chk = 0;
    n_err = 0;
    idle();
    rst_n = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    load(32'h40, SZ_W, 1'b0, rd);
    check("rst_rd", rd, 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    load(32'h40, SZ_W, 1'b0, rd);
    check("w40_rd", rd, 32'h0);
    check("w40_mis", {31'b0, misalign}, 32'h0);

    // sub-word loads and extension
    store(32'h10, 32'hDEADBEEF, SZ_W);
    load(32'h10, SZ_W, 1'b0, rd);
    check("w10", rd, 32'hDEADBEEF);
    load(32'h11, SZ_B, 1'b0, rd);
    check("b11_s", rd, 32'hFFFFFFBE);
    load(32'h11, SZ_B, 1'b1, rd);
    check("b11_u", rd, 32'h000000BE);
    load(32'h12, SZ_H, 1'b0, rd);
    check("h12_s", rd, 32'hFFFFDEAD);
    load(32'h10, SZ_H, 1'b1, rd);
    check("h10_u", rd, 32'h0000BEEF);
    load(32'h13, SZ_B, 1'b0, rd);
    check("b13_s", rd, 32'hFFFFFFDE);
    mem_read = 1'b0;
    #1;
    check("rd_off", read_data, 32'h0);

    // write disabled leaves array alone
    mem_write  = 1'b0;
    mem_size   = SZ_W;
    addr       = 32'h10;
    write_data = 32'h0BADF00D;
    @(posedge clk);
    #1;
    load(32'h10, SZ_W, 1'b0, rd);
    check("nowr", rd, 32'hDEADBEEF);

    // lane-merging stores
    store(32'h20, 32'h11223344, SZ_W);
    store(32'h23, 32'hFFFFFFAA, SZ_B);
    load(32'h20, SZ_W, 1'b0, rd);
    check("b23_st", rd, 32'hAA223344);
    store(32'h20, 32'hFFFF5566, SZ_H);
    load(32'h20, SZ_W, 1'b0, rd);
    check("h20_st", rd, 32'hAA225566);

    // misaligned accesses
    store(32'h04, 32'hCAFEF00D, SZ_W);
    mem_write  = 1'b1;
    mem_size   = SZ_W;
    addr       = 32'h06;
    write_data = 32'hFFFFFFFF;
    #1;
    check("w06_mis", {31'b0, misalign}, 32'h1);
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    load(32'h04, SZ_W, 1'b0, rd);
    check("w04_keep", rd, 32'hCAFEF00D);
    load(32'h03, SZ_H, 1'b0, rd);
    check("h03_mis", {31'b0, misalign}, 32'h1);
    check("h03_rd", rd, 32'h0);
    load(32'h00, SZ_X, 1'b0, rd);
    check("sz11_mis", {31'b0, misalign}, 32'h1);
    mem_read = 1'b0;
    #1;
    check("sz11_idle", {31'b0, misalign}, 32'h0);

    // address wrap
    store(32'h404, 32'h12345678, SZ_W);
    load(32'h004, SZ_W, 1'b0, rd);
    check("wrap", rd, 32'h12345678);

    // read and write same word in one cycle
    store(32'h30, 32'h1, SZ_W);
    mem_read   = 1'b1;
    mem_write  = 1'b1;
    mem_size   = SZ_W;
    addr       = 32'h30;
    write_data = 32'h2;
    #1;
    check("rw_pre", read_data, 32'h1);
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    check("rw_post", read_data, 32'h2);

    // async reset pulse between edges
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", read_data, 32'h0);
    rst_n = 1'b1;

    // reset held across an edge drops a pending store
    @(posedge clk);
    #1;
    mem_read   = 1'b0;
    mem_write  = 1'b1;
    addr       = 32'h50;
    write_data = 32'h77;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    rst_n     = 1'b1;
    load(32'h50, SZ_W, 1'b0, rd);
    check("rst_drop", rd, 32'h0);
    load(32'h10, SZ_W, 1'b0, rd);
    check("rst_clr", rd, 32'h0);

    // first store after reset release commits
    store(32'h54, 32'h0000ABCD, SZ_W);
    load(32'h54, SZ_W, 1'b0, rd);
    check("post_rst", rd, 32'h0000ABCD);

    idle();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
